gesture_thresh_ctrl: RTL and testbench
======================================

GESTURE_THRESH_CTRL -- requirements
Module: gesture_thresh_ctrl

Interface
REQ-001 The block SHALL have parameter CB_MAX_DEF, default 8'd127, reset value of the active/shadow Cb upper bound.
REQ-002 The block SHALL have parameter CB_MIN_DEF, default 8'd77, reset value of the Cb lower bound.
REQ-003 The block SHALL have parameter CR_MAX_DEF, default 8'd173, reset value of the Cr upper bound.
REQ-004 The block SHALL have parameter CR_MIN_DEF, default 8'd133, reset value of the Cr lower bound.
REQ-005 The block SHALL have parameter COUNT_W, default 20, skin-pixel counter width.
REQ-006 The block SHALL have port clk  input  1  the single clock.
REQ-007 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 The block SHALL have port cfg_wr_en  input  1  shadow-register write strobe.
REQ-009 The block SHALL have port cfg_addr  input  2  shadow select: 0=CB_MAX, 1=CB_MIN, 2=CR_MAX, 3=CR_MIN.
REQ-010 The block SHALL have port cfg_wr_data  input  8  shadow write data.
REQ-011 The block SHALL have port cfg_commit  input  1  single-cycle request to apply the shadow set at the next frame boundary.
REQ-012 The block SHALL have port cfg_busy  output  1  commit pending.
REQ-013 The block SHALL have port cfg_err  output  1  last commit rejected (sticky).
REQ-014 The block SHALL have port ycbcr_vsync  input  1  frame sync, high pulse at frame start.
REQ-015 The block SHALL have port det_valid  input  1  detector output pixel valid.
REQ-016 The block SHALL have port det_skin  input  1  detector classified pixel as skin (qualified by det_valid).
REQ-017 The block SHALL have ports cb_max, cb_min, cr_max, cr_min  output  8 each  active thresholds driving the detector.
REQ-018 The block SHALL have port skin_count  output  COUNT_W  skin pixels in last completed frame.
REQ-019 The block SHALL have port frame_done  output  1  one-cycle pulse, skin_count updated.

Function
REQ-020 Frame boundary (FB) SHALL be the cycle with ycbcr_vsync=1 and its registered copy=0.
REQ-021 cfg_wr_en SHALL write cfg_wr_data into the addressed shadow register at the next clock edge; writes are accepted in every state.
REQ-022 cfg_commit SHALL set the pending flag; cfg_busy SHALL equal pending; repeated commits while pending SHALL be absorbed.
REQ-023 At an FB with pending or cfg_commit asserted, the active set SHALL load the shadow contents held at the start of that cycle; a same-cycle write SHALL affect only the shadow; pending clears.
REQ-024 At that load, if shadow CB_MIN>=CB_MAX or CR_MIN>=CR_MAX, the active set SHALL remain unchanged and cfg_err SHALL set; cfg_err SHALL clear on the next cfg_commit.
REQ-025 Active thresholds SHALL change only at an FB, never mid-frame.
REQ-026 FSM states IDLE, IN_FRAME, REPORT; reset to IDLE.
REQ-027 IDLE->IN_FRAME at the first FB, with no report.
REQ-028 IN_FRAME->REPORT at an FB: skin_count loads the counter, the counter clears, and frame_done=1 on the cycle after the FB.
REQ-029 REPORT->IN_FRAME unconditionally after one cycle, or REPORT->REPORT if another FB occurs there.
REQ-030 The counter SHALL increment when det_valid & det_skin & ~ycbcr_vsync in IN_FRAME/REPORT, and SHALL saturate at 2^COUNT_W-1 without wrapping.
REQ-031 A pixel qualified in the FB cycle SHALL NOT be counted.

Reset
REQ-032 On rst: shadow and active = *_DEF, skin_count=0, counter=0, frame_done=0, cfg_busy=0, cfg_err=0, FSM=IDLE, vsync register=0.
REQ-033 rst asserted mid-frame SHALL discard the partial count and any pending commit.

Structure
REQ-034 Package gesture_pkg SHALL hold default thresholds, the cfg address map, the FSM state encoding and COUNT_W.
REQ-035 The shadow register file plus range check SHALL be sub-module gesture_cfg_regs; the FSM and counter remain top-level.

Verification
REQ-036 Reset -> outputs 127/77/173/133, skin_count=0, frame_done=0, cfg_busy=0.
REQ-037 Two frames with 1000 skin-valid pixels each -> no pulse at the first FB; frame_done pulse and skin_count=1000 at the second FB.
REQ-038 Write CB_MAX=120 and commit mid-frame -> cb_max stays 127 until the FB, becomes 120 on the cycle after; cfg_busy high in between.
REQ-039 Commit with CR_MIN=180 and CR_MAX=173 -> active unchanged at the FB, cfg_err=1; a valid commit then clears it.
REQ-040 Force COUNT_W=4 with 20 skin pixels -> skin_count=15.
REQ-041 Pulse rst mid-frame with a commit pending -> defaults restored, cfg_busy=0, no frame_done at the next FB.

Source files
------------

// File: rtl/gesture_pkg.sv
// Shared constants and types for the gesture threshold controller: default skin
// thresholds, the config address map, FSM encoding and the threshold-set record.
package gesture_pkg;

    localparam logic [7:0] CB_MAX_DEFAULT = 8'd127;
    localparam logic [7:0] CB_MIN_DEFAULT = 8'd77;
    localparam logic [7:0] CR_MAX_DEFAULT = 8'd173;
    localparam logic [7:0] CR_MIN_DEFAULT = 8'd133;
    localparam int         COUNT_W_DEFAULT = 20;

    typedef enum logic [1:0] {
        CFG_CB_MAX = 2'd0,
        CFG_CB_MIN = 2'd1,
        CFG_CR_MAX = 2'd2,
        CFG_CR_MIN = 2'd3
    } cfg_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_FRAME = 2'd1,
        ST_REPORT   = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] cb_max;
        logic [7:0] cb_min;
        logic [7:0] cr_max;
        logic [7:0] cr_min;
    } thresh_t;

    // A set is usable only if both windows are non-empty.
    function automatic logic thresh_ok(input thresh_t t);
        return (t.cb_min < t.cb_max) && (t.cr_min < t.cr_max);
    endfunction

endpackage

// File: rtl/gesture_thresh_ctrl_if.sv
// Configuration bus of the gesture threshold controller: shadow writes, commit
// request and the busy/error status returned by the block.
interface gesture_thresh_ctrl_if;

    logic       cfg_wr_en;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wr_data;
    logic       cfg_commit;
    logic       cfg_busy;
    logic       cfg_err;

    modport master (
        output cfg_wr_en,
        output cfg_addr,
        output cfg_wr_data,
        output cfg_commit,
        input  cfg_busy,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr_en,
        input  cfg_addr,
        input  cfg_wr_data,
        input  cfg_commit,
        output cfg_busy,
        output cfg_err
    );

endinterface

// File: rtl/gesture_cfg_regs.sv
// Shadow threshold registers with commit/validate logic; the active set is
// only reloaded from the shadow at a frame boundary.
module gesture_cfg_regs
    import gesture_pkg::*;
#(
    parameter logic [7:0] CB_MAX_DEF = CB_MAX_DEFAULT,
    parameter logic [7:0] CB_MIN_DEF = CB_MIN_DEFAULT,
    parameter logic [7:0] CR_MAX_DEF = CR_MAX_DEFAULT,
    parameter logic [7:0] CR_MIN_DEF = CR_MIN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    gesture_thresh_ctrl_if.slave       cfg,
    input  logic                       fb,
    output thresh_t                    active
);

    localparam thresh_t DEF_SET = {CB_MAX_DEF, CB_MIN_DEF, CR_MAX_DEF, CR_MIN_DEF};

    thresh_t shadow;
    logic    pending;
    logic    err;
    logic    load;
    logic    shadow_ok;

    assign load      = fb && (pending || cfg.cfg_commit);
    assign shadow_ok = thresh_ok(shadow);

    assign cfg.cfg_busy = pending;
    assign cfg.cfg_err  = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= DEF_SET;
        end else if (cfg.cfg_wr_en) begin
            case (cfg_addr_e'(cfg.cfg_addr))
                CFG_CB_MAX: shadow.cb_max <= cfg.cfg_wr_data;
                CFG_CB_MIN: shadow.cb_min <= cfg.cfg_wr_data;
                CFG_CR_MAX: shadow.cr_max <= cfg.cfg_wr_data;
                CFG_CR_MIN: shadow.cr_min <= cfg.cfg_wr_data;
                default:    shadow        <= shadow;
            endcase
        end
    end

    // Load samples the registered shadow, so a write in the boundary cycle
    // lands in the shadow only and waits for the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= DEF_SET;
            pending <= 1'b0;
            err     <= 1'b0;
        end else if (load) begin
            pending <= 1'b0;
            if (shadow_ok) begin
                active <= shadow;
                err    <= 1'b0;
            end else begin
                err    <= 1'b1;
            end
        end else if (cfg.cfg_commit) begin
            pending <= 1'b1;
            err     <= 1'b0;
        end
    end

endmodule

// File: rtl/gesture_thresh_ctrl.sv
// Frame-synchronous threshold controller for the skin detector: applies
// committed thresholds at frame start and reports the per-frame skin count.
module gesture_thresh_ctrl
    import gesture_pkg::*;
#(
    parameter logic [7:0] CB_MAX_DEF = CB_MAX_DEFAULT,
    parameter logic [7:0] CB_MIN_DEF = CB_MIN_DEFAULT,
    parameter logic [7:0] CR_MAX_DEF = CR_MAX_DEFAULT,
    parameter logic [7:0] CR_MIN_DEF = CR_MIN_DEFAULT,
    parameter int         COUNT_W    = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    gesture_thresh_ctrl_if.slave cfg,
    input  logic               ycbcr_vsync,
    input  logic               det_valid,
    input  logic               det_skin,
    output logic [7:0]         cb_max,
    output logic [7:0]         cb_min,
    output logic [7:0]         cr_max,
    output logic [7:0]         cr_min,
    output logic [COUNT_W-1:0] skin_count,
    output logic               frame_done
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_e             state;
    state_e             state_nxt;
    logic               vsync_q;
    logic               fb;
    logic               count_en;
    logic [COUNT_W-1:0] cnt;
    thresh_t            active;

    assign fb = ycbcr_vsync && !vsync_q;

    gesture_cfg_regs #(
        .CB_MAX_DEF (CB_MAX_DEF),
        .CB_MIN_DEF (CB_MIN_DEF),
        .CR_MAX_DEF (CR_MAX_DEF),
        .CR_MIN_DEF (CR_MIN_DEF)
    ) u_cfg_regs (
        .clk    (clk),
        .rst    (rst),
        .cfg    (cfg),
        .fb     (fb),
        .active (active)
    );

    assign cb_max = active.cb_max;
    assign cb_min = active.cb_min;
    assign cr_max = active.cr_max;
    assign cr_min = active.cr_min;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= ycbcr_vsync;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        count_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fb) state_nxt = ST_IN_FRAME;
            end
            ST_IN_FRAME: begin
                count_en = det_valid && det_skin && !ycbcr_vsync;
                if (fb) state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                frame_done = 1'b1;
                count_en   = det_valid && det_skin && !ycbcr_vsync;
                state_nxt  = fb ? ST_REPORT : ST_IN_FRAME;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counter restarts at every boundary; the boundary pixel itself is dropped
    // because vsync is high in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            skin_count <= '0;
        end else begin
            if (fb && state != ST_IDLE) skin_count <= cnt;
            if (fb) begin
                cnt <= '0;
            end else if (count_en && cnt != CNT_MAX) begin
                cnt <= cnt + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gesture_thresh_ctrl.sv
// Directed bench for gesture_thresh_ctrl: frame counting, shadow commit timing,
// rejected commits, reset mid-frame and counter saturation on a narrow instance.
module tb_gesture_thresh_ctrl;
    import gesture_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gesture_thresh_ctrl_if cfg_a ();
    gesture_thresh_ctrl_if cfg_b ();

    logic        vsync_a, valid_a, skin_a;
    logic [7:0]  cb_max_a, cb_min_a, cr_max_a, cr_min_a;
    logic [19:0] count_a;
    logic        done_a;

    logic        vsync_b, valid_b, skin_b;
    logic [7:0]  cb_max_b, cb_min_b, cr_max_b, cr_min_b;
    logic [3:0]  count_b;
    logic        done_b;

    gesture_thresh_ctrl u_dut (
        .clk (clk), .rst (rst), .cfg (cfg_a),
        .ycbcr_vsync (vsync_a), .det_valid (valid_a), .det_skin (skin_a),
        .cb_max (cb_max_a), .cb_min (cb_min_a), .cr_max (cr_max_a), .cr_min (cr_min_a),
        .skin_count (count_a), .frame_done (done_a)
    );

    gesture_thresh_ctrl #(.COUNT_W(4)) u_small (
        .clk (clk), .rst (rst), .cfg (cfg_b),
        .ycbcr_vsync (vsync_b), .det_valid (valid_b), .det_skin (skin_b),
        .cb_max (cb_max_b), .cb_min (cb_min_b), .cr_max (cr_max_b), .cr_min (cr_min_b),
        .skin_count (count_b), .frame_done (done_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       wr_en;
        logic [1:0] addr;
        logic [7:0] data;
        logic       commit;
        logic       vsync;
        logic [7:0] exp_cb_max;
        logic [7:0] exp_cr_min;
        logic       exp_busy;
        logic       exp_err;
        logic       exp_done;
        int         exp_count;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 8'd120, 1'b0, 1'b0, 8'd127, 8'd133, 1'b0, 1'b0, 1'b0, 1000};
        vecs[1]  = '{1'b0, 2'd0, 8'd0,   1'b1, 1'b0, 8'd127, 8'd133, 1'b1, 1'b0, 1'b0, 1000};
        vecs[2]  = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd127, 8'd133, 1'b1, 1'b0, 1'b0, 1000};
        vecs[3]  = '{1'b0, 2'd0, 8'd0,   1'b1, 1'b0, 8'd127, 8'd133, 1'b1, 1'b0, 1'b0, 1000};
        vecs[4]  = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 8'd120, 8'd133, 1'b0, 1'b0, 1'b1, 0};
        vecs[5]  = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd120, 8'd133, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b1, 2'd3, 8'd180, 1'b0, 1'b0, 8'd120, 8'd133, 1'b0, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 2'd0, 8'd0,   1'b1, 1'b0, 8'd120, 8'd133, 1'b1, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 8'd120, 8'd133, 1'b0, 1'b1, 1'b1, 0};
        vecs[9]  = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd120, 8'd133, 1'b0, 1'b1, 1'b0, 0};
        vecs[10] = '{1'b1, 2'd3, 8'd140, 1'b0, 1'b0, 8'd120, 8'd133, 1'b0, 1'b1, 1'b0, 0};
        vecs[11] = '{1'b0, 2'd0, 8'd0,   1'b1, 1'b0, 8'd120, 8'd133, 1'b1, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 8'd120, 8'd140, 1'b0, 1'b0, 1'b1, 0};
        vecs[13] = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd120, 8'd140, 1'b0, 1'b0, 1'b0, 0};
        vecs[14] = '{1'b1, 2'd0, 8'd100, 1'b1, 1'b1, 8'd120, 8'd140, 1'b0, 1'b0, 1'b1, 0};
        vecs[15] = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd120, 8'd140, 1'b0, 1'b0, 1'b0, 0};
        vecs[16] = '{1'b0, 2'd0, 8'd0,   1'b1, 1'b0, 8'd120, 8'd140, 1'b1, 1'b0, 1'b0, 0};
        vecs[17] = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 8'd100, 8'd140, 1'b0, 1'b0, 1'b1, 0};
        vecs[18] = '{1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd100, 8'd140, 1'b0, 1'b0, 1'b0, 0};

        rst = 1'b1;
        cfg_a.cfg_wr_en = 1'b0; cfg_a.cfg_addr = 2'd0; cfg_a.cfg_wr_data = 8'd0; cfg_a.cfg_commit = 1'b0;
        cfg_b.cfg_wr_en = 1'b0; cfg_b.cfg_addr = 2'd0; cfg_b.cfg_wr_data = 8'd0; cfg_b.cfg_commit = 1'b0;
        vsync_a = 1'b0; valid_a = 1'b0; skin_a = 1'b0;
        vsync_b = 1'b0; valid_b = 1'b0; skin_b = 1'b0;

        // Reset values
        #3;
        chk("rst_cb_max", int'(cb_max_a), 127);
        chk("rst_cb_min", int'(cb_min_a), 77);
        chk("rst_cr_max", int'(cr_max_a), 173);
        chk("rst_cr_min", int'(cr_min_a), 133);
        chk("rst_count", int'(count_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_busy", int'(cfg_a.cfg_busy), 0);
        chk("rst_err", int'(cfg_a.cfg_err), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Two frames of 1000 skin pixels; boundary pixels must not count
        vsync_a = 1'b1; valid_a = 1'b1; skin_a = 1'b1;
        tick();
        chk("fb1_no_done", int'(done_a), 0);
        vsync_a = 1'b0;
        repeat (1000) tick();
        chk("mid_frame_done", int'(done_a), 0);
        chk("mid_frame_count", int'(count_a), 0);
        vsync_a = 1'b1;
        tick();
        chk("fb2_done", int'(done_a), 1);
        chk("fb2_count", int'(count_a), 1000);
        vsync_a = 1'b0; valid_a = 1'b0; skin_a = 1'b0;
        tick();
        chk("fb2_done_drop", int'(done_a), 0);

        // Commit timing and error handling
        for (int i = 0; i < 19; i++) begin
            cfg_a.cfg_wr_en   = vecs[i].wr_en;
            cfg_a.cfg_addr    = vecs[i].addr;
            cfg_a.cfg_wr_data = vecs[i].data;
            cfg_a.cfg_commit  = vecs[i].commit;
            vsync_a           = vecs[i].vsync;
            tick();
            chk($sformatf("v%0d_cb_max", i), int'(cb_max_a), int'(vecs[i].exp_cb_max));
            chk($sformatf("v%0d_cr_min", i), int'(cr_min_a), int'(vecs[i].exp_cr_min));
            chk($sformatf("v%0d_busy", i), int'(cfg_a.cfg_busy), int'(vecs[i].exp_busy));
            chk($sformatf("v%0d_err", i), int'(cfg_a.cfg_err), int'(vecs[i].exp_err));
            chk($sformatf("v%0d_done", i), int'(done_a), int'(vecs[i].exp_done));
            chk($sformatf("v%0d_count", i), int'(count_a), vecs[i].exp_count);
        end
        cfg_a.cfg_wr_en = 1'b0; cfg_a.cfg_commit = 1'b0; vsync_a = 1'b0;

        // Reset mid-frame with a commit pending
        cfg_a.cfg_wr_en = 1'b1; cfg_a.cfg_addr = 2'd0; cfg_a.cfg_wr_data = 8'd90;
        tick();
        cfg_a.cfg_wr_en = 1'b0; cfg_a.cfg_commit = 1'b1;
        tick();
        cfg_a.cfg_commit = 1'b0;
        chk("pre_rst_busy", int'(cfg_a.cfg_busy), 1);
        valid_a = 1'b1; skin_a = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_cb_max", int'(cb_max_a), 127);
        chk("mid_rst_cr_min", int'(cr_min_a), 133);
        chk("mid_rst_busy", int'(cfg_a.cfg_busy), 0);
        chk("mid_rst_count", int'(count_a), 0);
        tick();
        rst = 1'b0;
        tick();
        vsync_a = 1'b1;
        tick();
        chk("post_rst_fb_done", int'(done_a), 0);
        chk("post_rst_fb_cb_max", int'(cb_max_a), 127);
        chk("post_rst_fb_busy", int'(cfg_a.cfg_busy), 0);
        vsync_a = 1'b0; valid_a = 1'b0; skin_a = 1'b0;
        tick();

        // Saturation on the 4-bit counter
        vsync_b = 1'b1; valid_b = 1'b1; skin_b = 1'b1;
        tick();
        vsync_b = 1'b0;
        repeat (20) tick();
        chk("sat_pre_done", int'(done_b), 0);
        vsync_b = 1'b1;
        tick();
        chk("sat_count", int'(count_b), 15);
        chk("sat_done", int'(done_b), 1);
        vsync_b = 1'b0; valid_b = 1'b0; skin_b = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
